fnd_scan_ctrl: RTL and testbench

FND_SCAN_CTRL -- requirements
Module: fnd_scan_ctrl

---
 rtl/fnd_scan_ctrl_pkg.sv | 45 ++++
 rtl/fnd_font_rom.sv | 23 ++
 rtl/fnd_scan_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_fnd_scan_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed seven-segment (FND) scan controller.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   BRIGHT_LEVELS  number of brightness steps a slot is divided into
//   FONT_TABLE     common-anode segment codes for hex 0..F, bit 7 = dp (1 = off)
//   disp_cfg_t     non-digit display settings held in the shadow/active sets
//   on_limit()     prescaler threshold below which the digit enable may be low

package fnd_scan_ctrl_pkg;

  localparam int BRIGHT_LEVELS = 8;

  // Entry 15 is listed first so FONT_TABLE[hex] selects the code directly.
  localparam logic [15:0][7:0] FONT_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,   // F E d C
    8'h83, 8'h88, 8'h90, 8'h80,   // b A 9 8
    8'hF8, 8'h82, 8'h92, 8'h99,   // 7 6 5 4
    8'hB0, 8'hA4, 8'hF9, 8'hC0    // 3 2 1 0
  };

  typedef struct packed {
    logic       blank_lz;
    logic [2:0] bright;
  } disp_cfg_t;

  // Display settings after reset: no blanking, full brightness.
  localparam disp_cfg_t CFG_RESET = '{blank_lz: 1'b0, bright: 3'd7};

  // Exclusive upper bound of the prescaler window in which the digit is
  // enabled: (bright+1) eighths of the slot. Cycle 0 of every slot is always
  // dark (ghosting guard), so with the shortest slot the bright-0 window
  // would be swallowed entirely; the bound is floored at 2 so every level
  // keeps at least one lit cycle.
  function automatic int on_limit(input int scan_div, input logic [2:0] bright);
    int lim;
    lim = (int'(bright) + 1) * (scan_div / BRIGHT_LEVELS);
    if (lim < 2) begin
      lim = 2;
    end
    return lim;
  endfunction

endpackage

// File: rtl/fnd_font_rom.sv
// Hex digit plus decimal point to active-low seven-segment pattern.
// Latency: combinational, zero cycles.
// Backpressure: none; pure lookup.
//
// Ports:
//   hex   4-bit hex code 0..F
//   dp    1 = decimal point lit (clears bit 7)
//   font  active-low segments, bit 7 = dp, bits 6:0 = g..a

import fnd_scan_ctrl_pkg::*;

module fnd_font_rom (
  input  logic [3:0] hex,
  input  logic       dp,
  output logic [7:0] font
);

  logic [7:0] code;

  assign code = FONT_TABLE[hex];
  assign font = {code[7] & ~dp, code[6:0]};

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode FND display.
// Latency: fnd_font/fnd_comm are registered, one cycle behind the scan state.
// Backpressure: none; load is always accepted into the pending set.
//
// Ports:
//   clk, reset     system clock, asynchronous active-high reset
//   digits         packed hex codes, digit k = [4k+3:4k], digit 0 rightmost
//   dp_mask        decimal point enable per digit (1 = lit)
//   blink_mask     blink enable per digit
//   blank_lz       leading-zero blanking enable
//   bright         brightness 0..7 (7 = full slot minus the guard cycle)
//   load           one-cycle strobe capturing the inputs above
//   fnd_font       active-low segment pattern, bit 7 = dp
//   fnd_comm       active-low digit enables, at most one low

import fnd_scan_ctrl_pkg::*;

module fnd_scan_ctrl #(
  parameter int N_DIGITS  = 4,
  parameter int SCAN_DIV  = 100_000,
  parameter int BLINK_DIV = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp_mask,
  input  logic [N_DIGITS-1:0]   blink_mask,
  input  logic                  blank_lz,
  input  logic [2:0]            bright,
  input  logic                  load,
  output logic [7:0]            fnd_font,
  output logic [N_DIGITS-1:0]   fnd_comm
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int LW = CW + 1;               // holds SCAN_DIV itself
  localparam int IW = $clog2(N_DIGITS);
  localparam int FW = $clog2(BLINK_DIV + 1);
  localparam int DW = 4 * N_DIGITS;

  // ---------------------------------------------------------------------
  // Scan timing: prescaler -> slot tick -> scan index -> frame tick
  // ---------------------------------------------------------------------
  logic [CW-1:0] presc;
  logic [IW-1:0] scan_idx;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  logic          slot_tick;
  logic          frame_tick;

  assign slot_tick  = (presc == CW'(SCAN_DIV - 1));
  assign frame_tick = slot_tick && (scan_idx == IW'(N_DIGITS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (slot_tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_idx <= '0;
    end else if (frame_tick) begin
      scan_idx <= '0;
    end else if (slot_tick) begin
      scan_idx <= scan_idx + 1'b1;
    end
  end

  // blink_phase flips once every BLINK_DIV frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (frame_cnt == FW'(BLINK_DIV - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Pending/active display sets. Loads only touch pending; the whole set
  // moves to active on a frame boundary so a frame never mixes two loads.
  // A load coinciding with the frame tick lands in pending while active
  // takes the previous pending contents (both are non-blocking updates).
  // ---------------------------------------------------------------------
  logic [DW-1:0]       pend_digits, act_digits;
  logic [N_DIGITS-1:0] pend_dp,     act_dp;
  logic [N_DIGITS-1:0] pend_blink,  act_blink;
  disp_cfg_t           pend_cfg,    act_cfg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_blink  <= '0;
      pend_cfg    <= CFG_RESET;
    end else if (load) begin
      pend_digits <= digits;
      pend_dp     <= dp_mask;
      pend_blink  <= blink_mask;
      pend_cfg    <= '{blank_lz: blank_lz, bright: bright};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_digits <= '0;
      act_dp     <= '0;
      act_blink  <= '0;
      act_cfg    <= CFG_RESET;
    end else if (frame_tick) begin
      act_digits <= pend_digits;
      act_dp     <= pend_dp;
      act_blink  <= pend_blink;
      act_cfg    <= pend_cfg;
    end
  end

  // ---------------------------------------------------------------------
  // Current-digit decode
  // ---------------------------------------------------------------------
  logic [N_DIGITS-1:0] zero_run;   // bit k: digit k and all above are zero
  logic [3:0]          cur_hex;
  logic                cur_dp;
  logic                lz_blank;
  logic                blink_blank;
  logic [7:0]          rom_font;

  always_comb begin
    logic run;
    zero_run = '0;
    run      = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      run         = run && (act_digits[4*k +: 4] == 4'h0);
      zero_run[k] = run;
    end
  end

  assign cur_hex     = act_digits[{scan_idx, 2'b00} +: 4];
  assign cur_dp      = act_dp[scan_idx];
  // The rightmost digit always shows, so "0" stays visible for a zero value.
  assign lz_blank    = act_cfg.blank_lz && (scan_idx != '0) && zero_run[scan_idx];
  assign blink_blank = blink_phase && act_blink[scan_idx];

  fnd_font_rom u_font_rom (
    .hex  (cur_hex),
    .dp   (cur_dp),
    .font (rom_font)
  );

  // ---------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------
  logic [LW-1:0]       on_lim;
  logic [7:0]          font_next;
  logic [N_DIGITS-1:0] comm_next;

  assign on_lim = LW'(on_limit(SCAN_DIV, act_cfg.bright));

  always_comb begin
    // Blink blanking also hides the dp; leading-zero blanking only fires on
    // zero digits, which never need a dp-only pattern in this display.
    font_next = rom_font;
    if (blink_blank) begin
      font_next = 8'hFF;
    end else if (lz_blank) begin
      font_next = {rom_font[7], 7'h7F};
    end
  end

  always_comb begin
    comm_next = '1;
    // presc == 0 is the ghosting guard: the segment lines settle on the new
    // digit's pattern before its common is driven.
    if ((presc != '0) && ({1'b0, presc} < on_lim)) begin
      comm_next[scan_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fnd_font <= 8'hFF;
      fnd_comm <= '1;
    end else begin
      fnd_font <= font_next;
      fnd_comm <= comm_next;
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed testbench for fnd_scan_ctrl with N_DIGITS=4, SCAN_DIV=8, BLINK_DIV=2.
// Latency: outputs observed one cycle after the scan position they reflect.
// Backpressure: n/a.

module tb_fnd_scan_ctrl;

  localparam int N  = 4;
  localparam int SD = 8;
  localparam int BD = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits = '0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  blink_mask = '0;
  logic        blank_lz = 1'b0;
  logic [2:0]  bright = 3'd7;
  logic        load = 1'b0;
  logic [7:0]  fnd_font;
  logic [3:0]  fnd_comm;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;   // rising edges since the last reset release

  always #5 clk = ~clk;

  fnd_scan_ctrl #(
    .N_DIGITS  (N),
    .SCAN_DIV  (SD),
    .BLINK_DIV (BD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digits     (digits),
    .dp_mask    (dp_mask),
    .blink_mask (blink_mask),
    .blank_lz   (blank_lz),
    .bright     (bright),
    .load       (load),
    .fnd_font   (fnd_font),
    .fnd_comm   (fnd_comm)
  );

  // Scan position (cycles since release) of frame f, slot s, slot cycle c.
  function automatic int pos(input int f, input int s, input int c);
    return f * SD * N + s * SD + c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance until the outputs reflect scan position p.
  task automatic goto_obs(input int p);
    while (cyc < p + 1) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load  = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp,
                         input logic [3:0] bl, input logic lz, input logic [2:0] br);
    digits     = d;
    dp_mask    = dp;
    blink_mask = bl;
    blank_lz   = lz;
    bright     = br;
    load       = 1'b1;
    tick();
    load       = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_checks++;
    if (fnd_font !== 8'hFF) begin
      n_fail++; $display("FAIL reset_font: got %h expected ff", fnd_font);
    end
    n_checks++;
    if (fnd_comm !== 4'b1111) begin
      n_fail++; $display("FAIL reset_comm: got %b expected 1111", fnd_comm);
    end
  endtask

  task automatic test_scan();
    logic [3:0] ec;
    do_reset();
    for (int k = 1; k <= 64; k++) begin
      int p, c, s;
      tick();
      p  = k - 1;
      c  = p % SD;
      s  = (p / SD) % N;
      ec = 4'b0001 << s;
      ec = (c == 0) ? 4'b1111 : ~ec;
      n_checks++;
      if (fnd_comm !== ec) begin
        n_fail++; $display("FAIL scan_comm cyc %0d: got %b expected %b", k, fnd_comm, ec);
      end
      n_checks++;
      if (fnd_font !== 8'hC0) begin
        n_fail++; $display("FAIL scan_font cyc %0d: got %h expected c0", k, fnd_font);
      end
    end
  endtask

  task automatic test_lz();
    logic [7:0] exp_a[4];
    logic [7:0] exp_b[4];
    logic [3:0] ec;
    exp_a = '{8'hA4, 8'h99, 8'hFF, 8'hFF};
    exp_b = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
    do_reset();
    do_load(16'h0042, 4'b0000, 4'b0000, 1'b1, 3'd7);
    goto_obs(pos(0, 3, 1));
    n_checks++;
    if (fnd_font !== 8'hC0) begin
      n_fail++; $display("FAIL lz_shadow: got %h expected c0", fnd_font);
    end
    for (int s = 0; s < N; s++) begin
      goto_obs(pos(1, s, 1));
      ec = 4'b0001 << s;
      ec = ~ec;
      n_checks++;
      if (fnd_font !== exp_a[s]) begin
        n_fail++; $display("FAIL lz_0042 digit %0d: got %h expected %h", s, fnd_font, exp_a[s]);
      end
      n_checks++;
      if (fnd_comm !== ec) begin
        n_fail++; $display("FAIL lz_comm digit %0d: got %b expected %b", s, fnd_comm, ec);
      end
    end
    do_load(16'h0000, 4'b0000, 4'b0000, 1'b1, 3'd7);
    for (int s = 0; s < N; s++) begin
      goto_obs(pos(2, s, 1));
      n_checks++;
      if (fnd_font !== exp_b[s]) begin
        n_fail++; $display("FAIL lz_0000 digit %0d: got %h expected %h", s, fnd_font, exp_b[s]);
      end
    end
  endtask

  task automatic test_dp();
    logic [7:0] exp_f[4];
    exp_f = '{8'h99, 8'hB0, 8'h24, 8'hF9};
    do_reset();
    do_load(16'h1234, 4'b0100, 4'b0000, 1'b0, 3'd7);
    for (int s = 0; s < N; s++) begin
      goto_obs(pos(1, s, 4));
      n_checks++;
      if (fnd_font !== exp_f[s]) begin
        n_fail++; $display("FAIL dp digit %0d: got %h expected %h", s, fnd_font, exp_f[s]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    do_load(16'h0001, 4'b0000, 4'b0000, 1'b0, 3'd7);
    do_load(16'h0007, 4'b0000, 4'b0000, 1'b0, 3'd7);
    goto_obs(pos(1, 0, 1));
    n_checks++;
    if (fnd_font !== 8'hF8) begin
      n_fail++; $display("FAIL last_load_wins: got %h expected f8", fnd_font);
    end
    do_load(16'h0003, 4'b0000, 4'b0000, 1'b0, 3'd7);
    while (cyc < pos(1, 3, 7)) tick();
    // This load's capture edge is the frame tick.
    do_load(16'h0009, 4'b0000, 4'b0000, 1'b0, 3'd7);
    goto_obs(pos(2, 0, 1));
    n_checks++;
    if (fnd_font !== 8'hB0) begin
      n_fail++; $display("FAIL load_on_tick_frame2: got %h expected b0", fnd_font);
    end
    goto_obs(pos(3, 0, 1));
    n_checks++;
    if (fnd_font !== 8'h90) begin
      n_fail++; $display("FAIL load_on_tick_frame3: got %h expected 90", fnd_font);
    end
  endtask

  task automatic test_blink();
    logic [7:0] exp_f[7];
    exp_f = '{8'h12, 8'hFF, 8'hFF, 8'h12, 8'h12, 8'hFF, 8'hFF};
    do_reset();
    do_load(16'h0005, 4'b0001, 4'b0001, 1'b0, 3'd7);
    for (int f = 1; f <= 7; f++) begin
      goto_obs(pos(f, 0, 2));
      n_checks++;
      if (fnd_font !== exp_f[f-1]) begin
        n_fail++; $display("FAIL blink frame %0d: got %h expected %h", f, fnd_font, exp_f[f-1]);
      end
      if (f == 2) begin
        goto_obs(pos(f, 1, 2));
        n_checks++;
        if (fnd_font !== 8'hC0) begin
          n_fail++; $display("FAIL blink_other_digit: got %h expected c0", fnd_font);
        end
      end
    end
  endtask

  task automatic test_bright();
    logic [2:0] lvl[3];
    int         lows_exp[3];
    logic [3:0] ec;
    lvl      = '{3'd0, 3'd3, 3'd7};
    lows_exp = '{1, 3, 7};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      int lows;
      do_load(16'h0000, 4'b0000, 4'b0000, 1'b0, lvl[i]);
      lows = 0;
      for (int c = 0; c < SD; c++) begin
        goto_obs(pos(i + 1, 1, c));
        ec = (c >= 1 && c <= lows_exp[i]) ? 4'b1101 : 4'b1111;
        if (fnd_comm[1] === 1'b0) lows++;
        n_checks++;
        if (fnd_comm !== ec) begin
          n_fail++; $display("FAIL bright%0d cycle %0d: got %b expected %b", lvl[i], c, fnd_comm, ec);
        end
      end
      n_checks++;
      if (lows !== lows_exp[i]) begin
        n_fail++; $display("FAIL bright%0d low_count: got %0d expected %0d", lvl[i], lows, lows_exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] ec;
    do_reset();
    do_load(16'h1234, 4'b1111, 4'b0000, 1'b0, 3'd7);
    while (cyc < pos(1, 2, 3)) tick();
    do_load(16'h5678, 4'b1111, 4'b0000, 1'b0, 3'd7);
    n_checks++;
    if (fnd_font !== 8'h24 || fnd_comm !== 4'b1011) begin
      n_fail++; $display("FAIL pre_reset: got %h/%b expected 24/1011", fnd_font, fnd_comm);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (fnd_font !== 8'hFF || fnd_comm !== 4'b1111) begin
      n_fail++; $display("FAIL async_reset: got %h/%b expected ff/1111", fnd_font, fnd_comm);
    end
    tick();
    reset = 1'b0;
    cyc   = 0;
    for (int f = 0; f < 2; f++) begin
      for (int s = 0; s < N; s++) begin
        goto_obs(pos(f, s, 1));
        ec = 4'b0001 << s;
        ec = ~ec;
        n_checks++;
        if (fnd_font !== 8'hC0 || fnd_comm !== ec) begin
          n_fail++; $display("FAIL post_reset f%0d s%0d: got %h/%b expected c0/%b", f, s, fnd_font, fnd_comm, ec);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_lz();
    test_dp();
    test_back_to_back();
    test_blink();
    test_bright();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
